// File: rtl/seven_seg_scan.sv
// seven_seg_scan: multiplexed seven-segment display scanner.
// A prescaler steps through NUM_DIGITS digits; new display data is staged in a
// pending register and copied to the active register only at the frame wrap.
// All display outputs are active-low and registered.
// Optional feature: define SEVEN_SEG_LZB_EN to enable leading-zero blanking.
module seven_seg_scan #(
    parameter int NUM_DIGITS = 4,
    parameter int CLK_DIV    = 100000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic                    load,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_start
);

    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PW = $clog2(CLK_DIV);
    localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_DIGITS - 1);
    localparam logic [PW-1:0] LAST_PRESC = PW'(CLK_DIV - 1);

    logic [PW-1:0]           r_presc;
    logic [IW-1:0]           r_idx;
    logic [4*NUM_DIGITS-1:0] r_pend_val,   r_act_val;
    logic [NUM_DIGITS-1:0]   r_pend_dp,    r_act_dp;
    logic [NUM_DIGITS-1:0]   r_pend_blank, r_act_blank;
    logic [6:0]              r_seg;
    logic                    r_dp;
    logic [NUM_DIGITS-1:0]   r_an;
    logic                    r_frame_start;

    logic                    w_tick;
    logic                    w_commit;
    logic [3:0]              w_nib;
    logic                    w_dp_req;
    logic                    w_blank_req;
    logic                    w_lzb;
    logic                    w_blank;
    logic [NUM_DIGITS-1:0]   w_an;

    function automatic logic [6:0] f_decode(input logic [3:0] nib);
        case (nib)
            4'h0: f_decode = 7'b1000000;
            4'h1: f_decode = 7'b1111001;
            4'h2: f_decode = 7'b0100100;
            4'h3: f_decode = 7'b0110000;
            4'h4: f_decode = 7'b0011001;
            4'h5: f_decode = 7'b0010010;
            4'h6: f_decode = 7'b0000010;
            4'h7: f_decode = 7'b1111000;
            4'h8: f_decode = 7'b0000000;
            4'h9: f_decode = 7'b0010000;
            4'hA: f_decode = 7'b0001000;
            4'hB: f_decode = 7'b0000011;
            4'hC: f_decode = 7'b1000110;
            4'hD: f_decode = 7'b0100001;
            4'hE: f_decode = 7'b0000110;
            default: f_decode = 7'b0001110;
        endcase
    endfunction

    assign w_tick   = (r_presc == LAST_PRESC);
    assign w_commit = w_tick && (r_idx == LAST_IDX);

    // Select the current digit's active data and work out whether it is dark.
    always_comb begin
        w_nib       = '0;
        w_dp_req    = 1'b0;
        w_blank_req = 1'b0;
        w_an        = '1;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (r_idx == IW'(i)) begin
                w_nib       = r_act_val[4*i +: 4];
                w_dp_req    = r_act_dp[i];
                w_blank_req = r_act_blank[i];
                w_an[i]     = 1'b0;
            end
        end
`ifdef SEVEN_SEG_LZB_EN
        // Blank when this nibble and every higher one are zero; digit 0 never.
        w_lzb = (r_idx != '0);
        for (int unsigned j = 0; j < NUM_DIGITS; j++) begin
            if ((IW'(j) >= r_idx) && (r_act_val[4*j +: 4] != 4'h0))
                w_lzb = 1'b0;
        end
`else
        w_lzb = 1'b0;
`endif
        w_blank = w_blank_req | w_lzb;
    end

    // Prescaler and digit index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_idx   <= '0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + 1'b1;
            if (w_tick)
                r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
        end
    end

    // Pending/active data; a load on the committing tick bypasses to active.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_val   <= '0;
            r_pend_dp    <= '0;
            r_pend_blank <= '0;
            r_act_val    <= '0;
            r_act_dp     <= '0;
            r_act_blank  <= '0;
        end else begin
            if (load) begin
                r_pend_val   <= value;
                r_pend_dp    <= dp_in;
                r_pend_blank <= blank_in;
            end
            if (w_commit) begin
                r_act_val   <= load ? value    : r_pend_val;
                r_act_dp    <= load ? dp_in    : r_pend_dp;
                r_act_blank <= load ? blank_in : r_pend_blank;
            end
        end
    end

    // Registered display drive and frame pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg         <= '1;
            r_dp          <= 1'b1;
            r_an          <= '1;
            r_frame_start <= 1'b0;
        end else begin
            r_seg         <= w_blank ? 7'b1111111 : f_decode(w_nib);
            r_dp          <= w_blank | ~w_dp_req;
            r_an          <= w_an;
            r_frame_start <= w_commit;
        end
    end

    assign seg         = r_seg;
    assign dp          = r_dp;
    assign an          = r_an;
    assign frame_start = r_frame_start;

endmodule

// File: doc/seven_seg_scan.md
SEVEN_SEG_SCAN -- requirements
Module: seven_seg_scan

Interface
REQ-001 Parameter NUM_DIGITS, default 4, number of multiplexed digits, legal range 1..8.
REQ-002 Parameter CLK_DIV, default 100000, clock cycles each digit stays lit, legal minimum 2.
REQ-003 Port clk, input, 1 bit, single system clock; all state changes on its rising edge.
REQ-004 Port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-005 Port value, input, 4*NUM_DIGITS bits, hex nibbles; nibble i drives digit i, digit 0 least significant.
REQ-006 Port dp_in, input, NUM_DIGITS bits, decimal point request per digit, 1 = lit.
REQ-007 Port blank_in, input, NUM_DIGITS bits, forced blank per digit, 1 = dark.
REQ-008 Port load, input, 1 bit, one-cycle strobe that captures value, dp_in and blank_in into the pending register.
REQ-009 Port seg, output, 7 bits, active-low segments; seg[0]=a through seg[6]=g.
REQ-010 Port dp, output, 1 bit, active-low decimal point.
REQ-011 Port an, output, NUM_DIGITS bits, active-low anode enables; at most one bit low.
REQ-012 Port frame_start, output, 1 bit, one-cycle pulse when scanning returns to digit 0.

Function
REQ-013 The prescaler SHALL count 0..CLK_DIV-1 and wrap; the terminal count (CLK_DIV-1) is the tick.
REQ-014 On a tick, the digit index SHALL advance by one, wrapping from NUM_DIGITS-1 to 0.
REQ-015 On a tick that wraps the index to 0, the pending register SHALL be copied to the active register, and frame_start SHALL be high in the following cycle.
REQ-016 If load and a committing tick occur in the same cycle, the newly loaded data SHALL go straight to the active register.
REQ-017 A load without a committing tick SHALL update only the pending register.
REQ-018 Repeated loads within one frame SHALL retain only the last one.
REQ-019 seg, dp and an SHALL be registered; they reflect the index and active register one cycle after those change.
REQ-020 Digit decoding SHALL use active-low codes 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-021 When the current digit is blanked, an[index] SHALL still be driven low, seg SHALL be 1111111 and dp SHALL be 1.
REQ-022 When the current digit is not blanked, dp SHALL be the inverse of the active dp bit for that digit.
REQ-023 With NUM_DIGITS=1, the index SHALL stay 0 and every tick SHALL be a committing tick.

Reset
REQ-024 While rst_n is low, the prescaler and index SHALL be 0 and the pending and active registers SHALL be all zero.
REQ-025 While rst_n is low, seg SHALL be 1111111, dp SHALL be 1, an SHALL be all ones and frame_start SHALL be 0.
REQ-026 Reset asserted mid-frame SHALL discard any uncommitted pending data.
REQ-027 In the first cycle after rst_n rises, an SHALL be ...1110 and digit 0 SHALL show 1000000.

Configuration
REQ-028 Macro SEVEN_SEG_LZB_EN, when defined, SHALL enable leading-zero blanking: digit i>0 is blanked when its nibble and every higher nibble are 0.
REQ-029 Under SEVEN_SEG_LZB_EN, digit 0 SHALL never be blanked by the leading-zero rule, and the dp request SHALL be ignored on digits blanked by that rule.
REQ-030 Without SEVEN_SEG_LZB_EN, zero digits SHALL display 1000000 unless blank_in is set.

Verification (NUM_DIGITS=4, CLK_DIV=4)
REQ-031 Reset, then release -> an follows 1110,1101,1011,0111,1110, each for 4 cycles; frame_start pulses once every 16 cycles.
REQ-032 Load value=16'hA3F0 mid-frame -> old data kept until the wrap; the next frame shows 1000000, 0001110, 0110000, 0001000 on digits 0..3.
REQ-033 Load coincident with the committing tick, value=16'h1234 -> digit 0 shows 0011001 in that frame.
REQ-034 Load blank_in=4'b0100, dp_in=4'b0101 -> digit 2 shows seg 1111111 with dp 1; digit 0 shows dp 0.
REQ-035 With SEVEN_SEG_LZB_EN, value=16'h0007 -> digits 3..1 show 1111111 and digit 0 shows 1111000; without the macro, digits 3..1 show 1000000.
REQ-036 Assert rst_n low mid-frame after a load -> outputs go to reset values immediately, and after release the display shows all zeros.
